// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants: response codes and default bus widths.
package axil_pkg;
  localparam int AXIL_ADDR_WIDTH = 16;
  localparam int AXIL_DATA_WIDTH = 32;
  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_ram_mem.sv
// Word RAM: one byte-enabled write port, two registered read ports (read-before-write).
module axil_ram_mem #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_WORDS  = 256,
  localparam int IDXW       = $clog2(MEM_WORDS),
  localparam int STRBW      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDXW-1:0]       waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRBW-1:0]      wstrb_i,
  input  logic                  a_en_i,
  input  logic                  a_zero_i,
  input  logic [IDXW-1:0]       a_addr_i,
  output logic [DATA_WIDTH-1:0] a_data_o,
  input  logic                  b_zero_i,
  input  logic [IDXW-1:0]       b_addr_i,
  output logic [DATA_WIDTH-1:0] b_data_o
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] a_data_q;
  logic [DATA_WIDTH-1:0] b_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < STRBW; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Output registers sample the array before this cycle's write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_en_i) a_data_q <= a_zero_i ? '0 : mem_q[a_addr_i];
      b_data_q <= b_zero_i ? '0 : mem_q[b_addr_i];
    end
  end

  assign a_data_o = a_data_q;
  assign b_data_o = b_data_q;
endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave word RAM with a side debug port for preload and inspection.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   debug_addr,
  output logic [DATA_WIDTH-1:0]   debug_data,
  input  logic [ADDR_WIDTH-1:0]   debug_wr_addr,
  input  logic [DATA_WIDTH-1:0]   debug_wr_data,
  input  logic                    debug_wr_en
);
  localparam int IDXW  = $clog2(MEM_WORDS);
  localparam int STRBW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-3:0] WORDS_LIM = (ADDR_WIDTH-2)'(MEM_WORDS);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2] >= WORDS_LIM;
  endfunction

  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRBW-1:0]      wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic ar_hs, aw_hs, w_hs, commit;
  logic                  mem_we;
  logic [IDXW-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRBW-1:0]      mem_wstrb;
  logic                  unused_bits;

  assign s_axil_arready = !rvalid_q || s_axil_rready;
  assign s_axil_awready = !aw_held_q;
  assign s_axil_wready  = !w_held_q;

  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  // Debug writes own the single RAM write port; a pending AXI commit waits a cycle.
  assign commit = aw_held_q && w_held_q && !debug_wr_en && (!bvalid_q || s_axil_bready);

  always_comb begin
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = out_of_range(s_axil_araddr) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
    end else if (s_axil_rready) begin
      rvalid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = out_of_range(awaddr_q) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
    end else if (s_axil_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = awaddr_q[2 +: IDXW];
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    if (debug_wr_en) begin
      mem_we    = !out_of_range(debug_wr_addr);
      mem_waddr = debug_wr_addr[2 +: IDXW];
      mem_wdata = debug_wr_data;
      mem_wstrb = '1;
    end else if (commit) begin
      mem_we = !out_of_range(awaddr_q);
    end
  end

  axil_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_mem (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .wstrb_i  (mem_wstrb),
    .a_en_i   (ar_hs),
    .a_zero_i (out_of_range(s_axil_araddr)),
    .a_addr_i (s_axil_araddr[2 +: IDXW]),
    .a_data_o (s_axil_rdata),
    .b_zero_i (out_of_range(debug_addr)),
    .b_addr_i (debug_addr[2 +: IDXW]),
    .b_data_o (debug_data)
  );

  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;

  assign unused_bits = ^{s_axil_arprot, s_axil_awprot, s_axil_araddr[1:0], awaddr_q[1:0],
                         debug_addr[1:0], debug_wr_addr[1:0]};
endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave: vector table, directed corner sequences, random scoreboard.
module tb_axil_ram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [15:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [15:0] debug_addr = '0;
  logic [31:0] debug_data;
  logic [15:0] debug_wr_addr = '0;
  logic [31:0] debug_wr_data = '0;
  logic        debug_wr_en = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [256];

  axil_ram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .debug_wr_addr(debug_wr_addr), .debug_wr_data(debug_wr_data),
    .debug_wr_en(debug_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        pre_en;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [15:0] rd_addr;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [15:0] a, input logic [31:0] d);
    debug_wr_addr = a;
    debug_wr_data = d;
    debug_wr_en   = 1'b1;
    tick();
    debug_wr_en   = 1'b0;
  endtask

  task automatic dbg_read(input logic [15:0] a, output logic [31:0] d);
    debug_addr = a;
    tick();
    d = debug_data;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    ok = 0;
    resp = 2'b11;
    s_axil_awaddr = a;
    s_axil_wdata  = d;
    s_axil_wstrb  = s;
    while (!ok && cyc < 100) begin
      s_axil_awvalid = !aw_done && (cyc >= aw_dly);
      s_axil_wvalid  = !w_done && (cyc >= w_dly);
      s_axil_bready  = (cyc >= b_dly);
      #1;
      if (s_axil_awvalid && s_axil_awready) aw_done = 1;
      if (s_axil_wvalid && s_axil_wready) w_done = 1;
      if (s_axil_bvalid && s_axil_bready) begin
        ok = 1;
        resp = s_axil_bresp;
      end
      tick();
      cyc++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp, output bit ok);
    bit ar_done = 0;
    int cyc = 0;
    int rcyc = 0;
    ok = 0;
    d = '0;
    resp = 2'b11;
    s_axil_araddr = a;
    while (!ok && cyc < 100) begin
      s_axil_arvalid = !ar_done;
      s_axil_rready  = ar_done && (rcyc >= r_dly);
      #1;
      if (s_axil_rvalid && s_axil_rready) begin
        ok = 1;
        d = s_axil_rdata;
        resp = s_axil_rresp;
      end
      if (ar_done) rcyc++;
      if (s_axil_arvalid && s_axil_arready) ar_done = 1;
      tick();
      cyc++;
    end
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;

    vecs[0] = '{16'h0020, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 0, 2, 2'b00, 16'h0020, 32'h00BB_00DD};
    vecs[1] = '{16'h0024, 1'b1, 32'h1122_3344, 32'h5566_7788, 4'b1111, 2, 0, 2'b00, 16'h0024, 32'h5566_7788};
    vecs[2] = '{16'h0028, 1'b1, 32'h1122_3344, 32'h5566_7788, 4'b0000, 1, 1, 2'b00, 16'h0028, 32'h1122_3344};
    vecs[3] = '{16'h002D, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 0, 0, 2'b00, 16'h002C, 32'h00FF_FFFF};
    vecs[4] = '{16'h0400, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 0, 0, 2'b10, 16'h0400, 32'h0000_0000};
    vecs[5] = '{16'h03FC, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b0011, 1, 0, 2'b00, 16'h03FC, 32'h0000_F00D};
    vecs[6] = '{16'hFFFC, 1'b0, 32'h0000_0000, 32'h1234_5678, 4'b1111, 0, 3, 2'b10, 16'hFFFE, 32'h0000_0000};

    // Reset state, observed while reset is still asserted
    tick(); tick(); tick();
    chk("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("rst_rdata", s_axil_rdata, 32'd0);
    chk("rst_rresp", 32'(s_axil_rresp), 32'd0);
    chk("rst_bresp", 32'(s_axil_bresp), 32'd0);
    chk("rst_debug_data", debug_data, 32'd0);
    chk("rst_arready", 32'(s_axil_arready), 32'd1);
    chk("rst_awready", 32'(s_axil_awready), 32'd1);
    chk("rst_wready", 32'(s_axil_wready), 32'd1);
    rst = 1'b0;
    tick();

    // Basic read after debug preload
    dbg_write(16'h0000, 32'hA5A5_A5A5);
    dbg_write(16'h0010, 32'h1234_5678);
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    #1;
    chk("t1_arready_pre", 32'(s_axil_arready), 32'd1);
    tick();
    s_axil_arvalid = 1'b0;
    chk("t1_rvalid", 32'(s_axil_rvalid), 32'd1);
    chk("t1_rdata", s_axil_rdata, 32'h1234_5678);
    chk("t1_rresp", 32'(s_axil_rresp), 32'd0);
    chk("t1_arready", 32'(s_axil_arready), 32'd1);
    tick();
    chk("t1_rvalid_drained", 32'(s_axil_rvalid), 32'd0);

    // Same-word collision: AXI read, debug read and debug write in one cycle
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1;
    debug_addr = 16'h0010;
    debug_wr_addr = 16'h0010; debug_wr_data = 32'h8765_4321; debug_wr_en = 1'b1;
    tick();
    s_axil_arvalid = 1'b0; debug_wr_en = 1'b0;
    chk("coll_axi_old", s_axil_rdata, 32'h1234_5678);
    chk("coll_dbg_old", debug_data, 32'h1234_5678);
    tick();
    chk("coll_dbg_new", debug_data, 32'h8765_4321);
    s_axil_rready = 1'b0;

    // Vector table: preload, AXI write, AXI read back, debug read back
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_en) dbg_write(vecs[i].addr, vecs[i].pre);
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 1, r, ok);
      chk($sformatf("vec%0d_b_done", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      axi_read(vecs[i].rd_addr, 0, d, r, ok);
      chk($sformatf("vec%0d_r_done", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
      chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      dbg_read(vecs[i].rd_addr, d);
      chk($sformatf("vec%0d_dbg", i), d, vecs[i].exp_rd);
    end
    dbg_read(16'h0000, d);
    chk("oor_no_alias_w0", d, 32'hA5A5_A5A5);
    dbg_read(16'h03FC, d);
    chk("oor_no_alias_w255", d, 32'h0000_F00D);

    // R backpressure; second AR accepted on the drain cycle
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    tick();
    s_axil_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_rvalid_hold%0d", i), 32'(s_axil_rvalid), 32'd1);
      chk($sformatf("t3_rdata_hold%0d", i), s_axil_rdata, 32'h8765_4321);
      chk($sformatf("t3_arready_low%0d", i), 32'(s_axil_arready), 32'd0);
      tick();
    end
    s_axil_araddr = 16'h0020; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    #1;
    chk("t3_arready_drain", 32'(s_axil_arready), 32'd1);
    tick();
    s_axil_arvalid = 1'b0;
    chk("t3_rvalid_second", 32'(s_axil_rvalid), 32'd1);
    chk("t3_rdata_second", s_axil_rdata, 32'h00BB_00DD);
    tick();
    chk("t3_rvalid_done", 32'(s_axil_rvalid), 32'd0);
    s_axil_rready = 1'b0;

    // AXI commit collides with a debug write; B held under backpressure
    s_axil_awaddr = 16'h0044; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h600D_CAFE; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b0;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("t5_awready_held", 32'(s_axil_awready), 32'd0);
    chk("t5_wready_held", 32'(s_axil_wready), 32'd0);
    chk("t5_bvalid_pre", 32'(s_axil_bvalid), 32'd0);
    debug_wr_addr = 16'h0040; debug_wr_data = 32'h0BAD_F00D; debug_wr_en = 1'b1;
    tick();
    debug_wr_en = 1'b0;
    chk("t5_bvalid_stalled", 32'(s_axil_bvalid), 32'd0);
    tick();
    chk("t5_bvalid_late", 32'(s_axil_bvalid), 32'd1);
    chk("t5_bresp", 32'(s_axil_bresp), 32'd0);
    chk("t5_awready_free", 32'(s_axil_awready), 32'd1);
    tick();
    chk("t5_bvalid_hold1", 32'(s_axil_bvalid), 32'd1);
    tick();
    chk("t5_bvalid_hold2", 32'(s_axil_bvalid), 32'd1);
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    chk("t5_bvalid_cleared", 32'(s_axil_bvalid), 32'd0);
    dbg_read(16'h0040, d);
    chk("t5_dbg_word", d, 32'h0BAD_F00D);
    dbg_read(16'h0044, d);
    chk("t5_axi_word", d, 32'h600D_CAFE);

    // Reset while a read response is pending
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    tick();
    s_axil_arvalid = 1'b0;
    chk("t6_rvalid_pending", 32'(s_axil_rvalid), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rvalid_dropped", 32'(s_axil_rvalid), 32'd0);
    chk("t6_rdata_zero", s_axil_rdata, 32'd0);
    chk("t6_arready", 32'(s_axil_arready), 32'd1);
    rst = 1'b0;
    tick();
    dbg_read(16'h0010, d);
    chk("t6_ram_kept", d, 32'h8765_4321);

    // Random traffic against a transaction-level memory model
    for (int w = 64; w < 192; w++) begin
      ref_mem[w] = $urandom;
      dbg_write(16'(w << 2), ref_mem[w]);
    end
    for (int n = 0; n < 40; n++) begin
      int          w;
      logic [15:0] a;
      logic [31:0] wd;
      logic [3:0]  st;
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(128, 191);
        ref_mem[w] = $urandom;
        dbg_write(16'(w << 2), ref_mem[w]);
      end
      if ($urandom_range(0, 7) == 0) a = 16'(16'h0400 + ($urandom_range(0, 4095) << 2) + $urandom_range(0, 3));
      else a = 16'(($urandom_range(64, 127) << 2) + $urandom_range(0, 3));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      axi_write(a, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
      chk($sformatf("rw%0d_done", n), 32'(ok), 32'd1);
      chk($sformatf("rw%0d_bresp", n), 32'(r), (a >= 16'h0400) ? 32'd2 : 32'd0);
      if (a < 16'h0400) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[a >> 2][8*b +: 8] = wd[8*b +: 8];
      end
    end
    for (int n = 0; n < 50; n++) begin
      logic [15:0] a;
      logic [31:0] exp;
      if ($urandom_range(0, 7) == 0) a = 16'(16'h0400 + ($urandom_range(0, 4095) << 2));
      else a = 16'(($urandom_range(64, 191) << 2) + $urandom_range(0, 3));
      exp = (a >= 16'h0400) ? 32'd0 : ref_mem[a >> 2];
      axi_read(a, $urandom_range(0, 3), d, r, ok);
      chk($sformatf("rr%0d_done", n), 32'(ok), 32'd1);
      chk($sformatf("rr%0d_rdata", n), d, exp);
      chk($sformatf("rr%0d_rresp", n), 32'(r), (a >= 16'h0400) ? 32'd2 : 32'd0);
      dbg_read(a, d);
      chk($sformatf("rr%0d_dbg", n), d, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
